// File: rtl/motor_cmd_pwm.sv
// Motor command decoder: two-byte UART frames set per-channel duty/dir/en, applied
// glitch-free at PWM period boundaries, with a watchdog that stops all motors on link silence.
module motor_cmd_pwm #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned TIMEOUT_CYC = 12000000
) (
  input  logic              WF_CLK,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [NUM_CH-1:0] pwm,
  output logic [NUM_CH-1:0] dir,
  output logic [NUM_CH-1:0] en,
  output logic              frame_err,
  output logic              timeout
);

  localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DUTY_W = 7;

  typedef enum logic {IDLE = 1'b0, GOT_HDR = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              hdr_ch_q, hdr_ch_d;
  logic                    hdr_dir_q, hdr_dir_d;
  logic                    hdr_en_q, hdr_en_d;
  logic                    is_hdr_c, ch_ok_c, commit_c, frame_err_d;

  logic [DUTY_W-1:0]       sh_duty_q [NUM_CH];
  logic [DUTY_W-1:0]       sh_duty_d [NUM_CH];
  logic [DUTY_W-1:0]       act_duty_q [NUM_CH];
  logic [DUTY_W-1:0]       act_duty_d [NUM_CH];
  logic [NUM_CH-1:0]       sh_dir_q, sh_dir_d, sh_en_q, sh_en_d;
  logic [NUM_CH-1:0]       act_dir_q, act_dir_d, act_en_q, act_en_d;

  logic [PS_W-1:0]         presc_q, presc_d;
  logic [PWM_W-1:0]        cnt_q, cnt_d;
  logic                    tick_c, wrap_c;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    expire_c, timeout_d;
  logic [NUM_CH-1:0]       pwm_d;
  logic                    unused_bits;

  assign unused_bits = ^rx_data[1:0];
  assign is_hdr_c    = rx_data[7];
  assign ch_ok_c     = ({1'b0, hdr_ch_q} < 4'(NUM_CH));

  // Frame decoder FSM state and header latch
  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      hdr_ch_q  <= '0;
      hdr_dir_q <= 1'b0;
      hdr_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_ch_q  <= hdr_ch_d;
      hdr_dir_q <= hdr_dir_d;
      hdr_en_q  <= hdr_en_d;
    end
  end

  // A header always (re)latches; a data byte commits only after a header
  always_comb begin
    state_d     = state_q;
    hdr_ch_d    = hdr_ch_q;
    hdr_dir_d   = hdr_dir_q;
    hdr_en_d    = hdr_en_q;
    commit_c    = 1'b0;
    frame_err_d = 1'b0;
    if (rx_valid) begin
      if (is_hdr_c) begin
        state_d   = GOT_HDR;
        hdr_ch_d  = rx_data[6:4];
        hdr_dir_d = rx_data[3];
        hdr_en_d  = rx_data[2];
      end else if (state_q == IDLE) begin
        frame_err_d = 1'b1;
      end else begin
        state_d     = IDLE;
        commit_c    = ch_ok_c;
        frame_err_d = !ch_ok_c;
      end
    end
  end

  // Timebase, watchdog, shadow/active update
  always_comb begin
    tick_c    = (presc_q == PS_W'(PRESCALE - 1));
    presc_d   = tick_c ? '0 : presc_q + PS_W'(1);
    wrap_c    = tick_c && (cnt_q == '1);
    cnt_d     = tick_c ? cnt_q + PWM_W'(1) : cnt_q;

    expire_c  = !commit_c && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    if (commit_c)                       wd_d = '0;
    else if (wd_q == WD_W'(TIMEOUT_CYC)) wd_d = wd_q;
    else                                wd_d = wd_q + WD_W'(1);
    timeout_d = commit_c ? 1'b0 : (expire_c ? 1'b1 : timeout);

    sh_duty_d  = sh_duty_q;
    sh_dir_d   = sh_dir_q;
    sh_en_d    = sh_en_q;
    act_duty_d = act_duty_q;
    act_dir_d  = act_dir_q;
    act_en_d   = act_en_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (commit_c && (hdr_ch_q == 3'(i))) begin
        sh_duty_d[i] = rx_data[6:0];
        sh_dir_d[i]  = hdr_dir_q;
        sh_en_d[i]   = hdr_en_q;
      end
    end
    // Expiry stops immediately; otherwise the wrap takes the just-written shadow
    if (expire_c) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_duty_d[i]  = '0;
        act_duty_d[i] = '0;
      end
      sh_dir_d  = '0;
      sh_en_d   = '0;
      act_dir_d = '0;
      act_en_d  = '0;
    end else if (wrap_c) begin
      act_duty_d = sh_duty_d;
      act_dir_d  = sh_dir_d;
      act_en_d   = sh_en_d;
    end
  end

  // PWM compare: duty scaled to counter width, full-scale duty forced high
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = act_en_q[i] &&
                 ((act_duty_q[i] == 7'h7F) ||
                  (cnt_q < (PWM_W'(act_duty_q[i]) << (PWM_W - DUTY_W))));
    end
  end

  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_duty_q[i]  <= '0;
        act_duty_q[i] <= '0;
      end
      sh_dir_q  <= '0;
      sh_en_q   <= '0;
      act_dir_q <= '0;
      act_en_q  <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      pwm       <= '0;
      dir       <= '0;
      en        <= '0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      sh_duty_q  <= sh_duty_d;
      act_duty_q <= act_duty_d;
      sh_dir_q   <= sh_dir_d;
      sh_en_q    <= sh_en_d;
      act_dir_q  <= act_dir_d;
      act_en_q   <= act_en_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      pwm        <= pwm_d;
      dir        <= act_dir_q;
      en         <= act_en_q;
      frame_err  <= frame_err_d;
      timeout    <= timeout_d;
    end
  end

endmodule
